// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchroniser, tick-qualified debounce and
// registered edge detection for asynchronous level inputs.
module input_conditioner #(
    parameter int              WIDTH     = 1,
    parameter int              STAGES    = 2,
    parameter int              DB_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] indata,
    input  logic             tick,
    output logic [WIDTH-1:0] outdata,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Counter only needs to reach DB_CYCLES-1; keep at least one bit so the
    // bypass configuration still elaborates.
    localparam int              CNT_W    = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;
    localparam int              LAST     = (DB_CYCLES > 0) ? DB_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [STAGES-1:0][WIDTH-1:0] sync_pipe;
    logic [WIDTH-1:0]             sync;
    logic [WIDTH-1:0][CNT_W-1:0]  cnt;
    logic [WIDTH-1:0][CNT_W-1:0]  cnt_nxt;
    logic [WIDTH-1:0]             out_nxt;

    assign sync = sync_pipe[STAGES-1];

    // Plain flop chain per channel, nothing between stages, for metastability settling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_pipe <= {STAGES{RESET_VAL}};
        end else begin
            sync_pipe <= {sync_pipe[STAGES-2:0], indata};
        end
    end

    // Debounce decision: count ticks of sustained disagreement, commit on the last one.
    always_comb begin
        out_nxt = outdata;
        cnt_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (DB_CYCLES == 0) begin
                out_nxt[i] = sync[i];
            end else if (sync[i] != outdata[i]) begin
                if (!tick) begin
                    cnt_nxt[i] = cnt[i];
                end else if (cnt[i] < CNT_LAST) begin
                    cnt_nxt[i] = cnt[i] + CNT_ONE;
                end else begin
                    out_nxt[i] = sync[i];
                end
            end
        end
    end

    // Output level, counters and edge pulses; pulses line up with the new outdata value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outdata <= RESET_VAL;
            cnt     <= '0;
            rise    <= '0;
            fall    <= '0;
        end else begin
            outdata <= out_nxt;
            cnt     <= cnt_nxt;
            rise    <= out_nxt & ~outdata;
            fall    <= ~out_nxt & outdata;
        end
    end

    assign changed = |(rise | fall);

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed vector tables on single-channel
// instances plus a randomized 4-channel run against a behavioural model.
module tb_input_conditioner;

    localparam logic [3:0] RV_B = 4'b1000;
    localparam int         DB_B = 4;
    localparam int         ST_B = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_a, tick_a, out_a, rise_a, fall_a, chg_a;
    logic [3:0] in_b, out_b, rise_b, fall_b;
    logic       tick_b, chg_b;
    logic       in_c, tick_c, out_c, rise_c, fall_c, chg_c;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    input_conditioner #(.WIDTH(1), .STAGES(2), .DB_CYCLES(4)) u_a (
        .clk(clk), .reset(reset), .indata(in_a), .tick(tick_a),
        .outdata(out_a), .rise(rise_a), .fall(fall_a), .changed(chg_a));

    input_conditioner #(.WIDTH(4), .STAGES(ST_B), .DB_CYCLES(DB_B), .RESET_VAL(RV_B)) u_b (
        .clk(clk), .reset(reset), .indata(in_b), .tick(tick_b),
        .outdata(out_b), .rise(rise_b), .fall(fall_b), .changed(chg_b));

    input_conditioner #(.WIDTH(1), .STAGES(3), .DB_CYCLES(0)) u_c (
        .clk(clk), .reset(reset), .indata(in_c), .tick(tick_c),
        .outdata(out_c), .rise(rise_c), .fall(fall_c), .changed(chg_c));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model for u_b ----------------
    // Synchroniser is a pure delay of STAGES samples; a channel commits to the
    // synchronised value once it has disagreed for DB_B ticks without a break.
    logic [3:0] m_q[$];
    logic [3:0] m_out, m_rise, m_fall, m_s, m_prev;
    int         m_ticks[4];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q = {};
            for (int k = 0; k < ST_B; k++) m_q.push_back(RV_B);
            m_out  = RV_B;
            m_rise = '0;
            m_fall = '0;
            for (int k = 0; k < 4; k++) m_ticks[k] = 0;
        end else begin
            m_q.push_back(in_b);
            m_s    = m_q.pop_front();
            m_prev = m_out;
            for (int k = 0; k < 4; k++) begin
                if (m_s[k] == m_out[k]) begin
                    m_ticks[k] = 0;
                end else if (tick_b) begin
                    m_ticks[k] = m_ticks[k] + 1;
                    if (m_ticks[k] >= DB_B) begin
                        m_out[k]   = m_s[k];
                        m_ticks[k] = 0;
                    end
                end
            end
            m_rise = m_out & ~m_prev;
            m_fall = ~m_out & m_prev;
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("model_b", 32'({out_b, rise_b, fall_b, chg_b}),
                  32'({m_out, m_rise, m_fall, |(m_rise | m_fall)}));
    end

    // ---------------- vector table ----------------
    typedef struct {
        int   ph;
        logic sel;
        logic rst;
        logic din;
        logic tk;
        logic o;
        logic r;
        logic f;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int ph, logic sel, logic rst, logic din, logic tk,
                                logic o, logic r, logic f);
        tbl.push_back('{ph, sel, rst, din, tk, o, r, f});
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        reset = v.rst;
        if (v.sel == 1'b0) begin
            in_a = v.din; tick_a = v.tk;
        end else begin
            in_c = v.din; tick_c = v.tk;
        end
        @(posedge clk); #1;
        if (v.sel == 1'b0)
            check($sformatf("vec_a[%0d]", idx), 32'({out_a, rise_a, fall_a, chg_a}),
                  32'({v.o, v.r, v.f, v.r | v.f}));
        else
            check($sformatf("vec_c[%0d]", idx), 32'({out_c, rise_c, fall_c, chg_c}),
                  32'({v.o, v.r, v.f, v.r | v.f}));
    endtask

    task automatic run_phase(input int ph);
        foreach (tbl[k]) if (tbl[k].ph == ph) run_vec(tbl[k], k);
    endtask

    int hold;

    initial begin
        reset  = 1'b1;
        in_a   = 1'b0; tick_a = 1'b1;
        in_b   = RV_B; tick_b = 1'b1;
        in_c   = 1'b0; tick_c = 1'b0;

        // Phase 1, u_a: reset, quiet release, rising step, falling step, glitch, step.
        add(1, 0, 1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0, 0, 0);
        repeat (3) add(1, 0, 0, 0, 1, 0, 0, 0);
        repeat (5) add(1, 0, 0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 1, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 1, 0, 0);
        repeat (5) add(1, 0, 0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 1, 0, 0, 0);
        repeat (3) add(1, 0, 0, 1, 1, 0, 0, 0);
        repeat (4) add(1, 0, 0, 0, 1, 0, 0, 0);
        repeat (5) add(1, 0, 0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 1, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 1, 0, 0);
        // Phase 1, u_c (bypass, 3 stages, tick held low).
        repeat (3) add(1, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) add(1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 1, 1, 0);
        add(1, 1, 0, 1, 0, 1, 0, 0);
        repeat (3) add(1, 1, 0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 0);
        // Phase 2, u_a: requalify from scratch after reset, then slow-tick fall.
        repeat (5) add(2, 0, 0, 1, 1, 0, 0, 0);
        add(2, 0, 0, 1, 1, 1, 1, 0);
        add(2, 0, 0, 1, 1, 1, 0, 0);
        for (int k = 0; k < 17; k++)
            add(2, 0, 0, 0, (k % 4 == 3), (k < 15), 0, (k == 15));

        run_vec(tbl[0], 0);
        chk_en = 1'b1;
        foreach (tbl[k]) if (tbl[k].ph == 1 && k > 0) run_vec(tbl[k], k);

        // Reset in the middle of a falling qualification on u_a (count reaches 2).
        in_a = 1'b0; tick_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("rstmid_pre[%0d]", k), 32'({out_a, rise_a, fall_a}), 32'(3'b100));
        end
        reset = 1'b1; in_a = 1'b1;
        #1;
        check("rstmid_async", 32'({out_a, rise_a, fall_a, chg_a}), 32'(0));
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check($sformatf("rstmid_hold[%0d]", k), 32'({out_a, rise_a, fall_a, chg_a}), 32'(0));
        end
        reset = 1'b0;
        run_phase(2);

        // Simultaneous opposite transitions on u_b: bit0 rises, bit3 falls.
        in_b = 4'b0001; tick_b = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            if (k == 5)
                check("simul_edge", 32'({out_b, rise_b, fall_b, chg_b}),
                      32'({4'b0001, 4'b0001, 4'b1000, 1'b1}));
            else
                check($sformatf("simul_quiet[%0d]", k), 32'({out_b, rise_b, fall_b, chg_b}),
                      32'({(k < 5) ? 4'b1000 : 4'b0001, 8'h00, 1'b0}));
        end

        // Randomized run on u_b, including short glitches, slow ticks and stray resets.
        hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (hold == 0) begin
                in_b = 4'($urandom);
                hold = $urandom_range(1, 12);
            end
            hold   = hold - 1;
            tick_b = ($urandom_range(0, 3) != 0);
            reset  = ($urandom_range(0, 499) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter WIDTH, default 1, number of independent input channels (>=1).
REQ-002 SHALL have parameter STAGES, default 2, synchroniser flop depth per channel (>=2).
REQ-003 SHALL have parameter DB_CYCLES, default 4, debounce qualification count in tick cycles (0 = debounce bypass).
REQ-004 SHALL have parameter RESET_VAL, default {WIDTH{1'b0}}, WIDTH-bit reset level of synchroniser flops and outdata.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port indata  input  WIDTH  asynchronous raw inputs, one bit per channel.
REQ-008 SHALL have port tick  input  1  debounce sample strobe, synchronous to clk (tie high for per-clock debounce).
REQ-009 SHALL have port outdata  output  WIDTH  synchronised, debounced level per channel.
REQ-010 SHALL have port rise  output  WIDTH  one-clk pulse per channel when outdata goes 0->1.
REQ-011 SHALL have port fall  output  WIDTH  one-clk pulse per channel when outdata goes 1->0.
REQ-012 SHALL have port changed  output  1  OR-reduction of (rise | fall).

Function
REQ-013 SHALL pass each indata bit through a chain of STAGES flops; sync[i] = last stage; no logic between stages.
REQ-014 SHALL keep a per-channel counter cnt[i], width $clog2(DB_CYCLES+1) (min 1 bit), fully independent per channel.
REQ-015 SHALL, when sync[i]==outdata[i], clear cnt[i] to 0 on that edge regardless of tick.
REQ-016 SHALL, when sync[i]!=outdata[i] and tick=0, hold cnt[i].
REQ-017 SHALL, when sync[i]!=outdata[i], tick=1, cnt[i]<DB_CYCLES-1, increment cnt[i].
REQ-018 SHALL, when sync[i]!=outdata[i], tick=1, cnt[i]>=DB_CYCLES-1, load outdata[i]<=sync[i] and clear cnt[i].
REQ-019 SHALL, for DB_CYCLES=0, load outdata[i]<=sync[i] every clk edge; counters unused.
REQ-020 SHALL, with tick=1 and a stable input step, change outdata STAGES+max(DB_CYCLES,1) edges after the first edge sampling the new indata.
REQ-021 SHALL abandon a qualification (cnt to 0, outdata unchanged) if sync[i] returns to outdata[i] before qualification completes; glitches shorter than DB_CYCLES ticks never reach outdata.
REQ-022 SHALL register rise/fall so each asserts in exactly the cycle outdata[i] first shows its new value, for exactly one clk.
REQ-023 SHALL never assert rise[i] and fall[i] in the same cycle; simultaneous transitions on different channels assert their own bits in the same cycle.
REQ-024 SHALL derive changed combinationally from registered rise/fall (no extra latency).
REQ-025 SHALL not saturate or wrap cnt past DB_CYCLES-1.

Reset
REQ-026 SHALL, on reset=1, asynchronously set all synchroniser flops and outdata to RESET_VAL, cnt to 0, rise/fall to 0.
REQ-027 SHALL abort any in-progress qualification on reset, with no rise/fall pulse during reset or on the first edge after deassertion.
REQ-028 SHALL, after reset deassertion with indata equal to RESET_VAL, produce no pulses.
REQ-029 SHALL, after reset deassertion with indata differing from RESET_VAL, qualify it as a normal step per REQ-020.

Verification
REQ-030 SHALL cover: WIDTH=1,STAGES=2,DB=4,tick=1, indata 0->1 held -> outdata=1 and rise=1 for one clk at edge 6, changed=1 same cycle.
REQ-031 SHALL cover: DB=4,tick=1, 3-clk-wide high glitch after sync -> outdata stays 0, no rise/fall, cnt back to 0.
REQ-032 SHALL cover: DB=4, tick every 4th clk, step held -> outdata changes on the 4th tick after sync shows new value, not before.
REQ-033 SHALL cover: WIDTH=4, bit0 rises and bit3 falls on the same edge -> rise=4'b0001, fall=4'b1000 same cycle, changed=1.
REQ-034 SHALL cover: reset asserted mid-qualification (cnt=2) -> outdata=RESET_VAL immediately, cnt=0, no pulses; re-qualifies from scratch after release.
REQ-035 SHALL cover: DB_CYCLES=0,STAGES=3, step -> outdata follows at edge 4, one rise pulse.
